// File: rtl/taptempo_avg_pkg.sv
// Shared state encoding, default parameters and tick arithmetic for the averaging tap-tempo core.
package taptempo_avg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned     TP_CYCLE_DEF  = 32'd5120;
    localparam int unsigned     BPM_MAX_DEF   = 32'd250;
    localparam int unsigned     BPM_MIN_DEF   = 32'd30;
    localparam int unsigned     AVG_DEPTH_DEF = 32'd4;
    localparam longint unsigned NS_PER_MIN    = 64'd60_000_000_000;

    // Timepulse ticks in one minute for a given timepulse period in ns.
    function automatic longint unsigned ticks_per_min(input longint unsigned tp_cycle_ns);
        return NS_PER_MIN / tp_cycle_ns;
    endfunction

endpackage

// File: rtl/taptempo_avg_seqdiv.sv
// seqdiv: generic unsigned restoring divider producing Q_W quotient bits, one bit per cycle.
// The caller guarantees num_i / den_i < 2**Q_W, so only Q_W alignment steps are needed.
module seqdiv #(
    parameter int unsigned NUM_W = 32'd27,
    parameter int unsigned DEN_W = 32'd21,
    parameter int unsigned Q_W   = 32'd8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [Q_W-1:0]   q_o,
    output logic             done_o
);

    localparam int unsigned W     = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;
    localparam int unsigned CNT_W = (Q_W > 32'd2) ? $clog2(Q_W) : 32'd1;

    logic [W-1:0]     rem_r;
    logic [W-1:0]     dsh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic [Q_W-1:0]   q_r;
    logic             done_r;
    logic             ge_s;

    assign ge_s   = (rem_r >= dsh_r);
    assign q_o    = q_r;
    assign done_o = done_r;

    // Load operands on start, then one restoring step per cycle from the MSB down.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_r  <= {W{1'b0}};
            dsh_r  <= {W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            run_r  <= 1'b0;
            q_r    <= {Q_W{1'b0}};
            done_r <= 1'b0;
        end else if (start_i) begin
            rem_r  <= W'(num_i);
            dsh_r  <= W'(den_i) << (Q_W - 32'd1);
            cnt_r  <= CNT_W'(Q_W - 32'd1);
            run_r  <= 1'b1;
            q_r    <= {Q_W{1'b0}};
            done_r <= 1'b0;
        end else if (run_r) begin
            if (ge_s) begin
                rem_r <= rem_r - dsh_r;
            end else begin
                rem_r <= rem_r;
            end
            q_r   <= {q_r[Q_W-2:0], ge_s};
            dsh_r <= dsh_r >> 1;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(0)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                run_r  <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

endmodule

// File: rtl/taptempo_avg.sv
// taptempo_avg: averages the last AVG_DEPTH tap periods and divides them into a BPM value.
// Optional `TAPTEMPO_TIMEOUT_EN: a full-scale gap in COUNT abandons the measurement and returns to IDLE.
module taptempo_avg
    import taptempo_avg_pkg::*;
#(
    parameter  int unsigned TP_CYCLE  = TP_CYCLE_DEF,
    parameter  int unsigned BPM_MAX   = BPM_MAX_DEF,
    parameter  int unsigned BPM_MIN   = BPM_MIN_DEF,
    parameter  int unsigned AVG_DEPTH = AVG_DEPTH_DEF,
    localparam int unsigned BPM_W     = $clog2(BPM_MAX + 32'd1),
    localparam int unsigned FILL_W    = $clog2(AVG_DEPTH + 32'd1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tp_i,
    input  logic              btn_i,
    output logic [BPM_W-1:0]  bpm_o,
    output logic              bpm_valid_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              busy_o
);

    localparam longint unsigned TPM     = ticks_per_min(64'(TP_CYCLE));
    localparam longint unsigned PER_MIN = TPM / BPM_MAX;
    localparam longint unsigned PER_MAX = TPM / BPM_MIN;
    localparam int unsigned     PER_W   = $clog2(PER_MAX + 64'd1);
    localparam int unsigned     PTR_W   = $clog2(AVG_DEPTH);
    localparam int unsigned     SUM_W   = PER_W + PTR_W;
    localparam int unsigned     TPM_W   = $clog2(TPM + 64'd1);
    localparam int unsigned     NUM_W   = TPM_W + FILL_W;

    logic              btn_q_r;
    logic              tap_s;
    logic [PER_W-1:0]  cnt_r;
    logic [PER_W-1:0]  p_s;
    logic [PER_W-1:0]  p_r;
    logic              upd_r;
    logic [PER_W-1:0]  ring_r [AVG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [SUM_W-1:0]  sum_r;
    logic [SUM_W-1:0]  sum_nx_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nx_s;
    logic [PER_W-1:0]  oldest_s;
    state_t            state_r;
    state_t            state_nx_s;
    logic              pend_r;
    logic              pend_nx_s;
    logic              timeout_s;
    logic              clear_s;
    logic              start_s;
    logic [NUM_W-1:0]  num_s;
    logic [BPM_W-1:0]  q_s;
    logic              done_s;

    assign tap_s  = btn_i & ~btn_q_r;
    assign fill_o = fill_r;
    assign num_s  = NUM_W'(TPM) * NUM_W'(fill_nx_s);

    // Button edge register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q_r <= 1'b0;
        end else begin
            btn_q_r <= btn_i;
        end
    end

    // Tick counter: a tap restarts it and outranks a simultaneous timepulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {PER_W{1'b0}};
        end else if (tap_s) begin
            cnt_r <= {PER_W{1'b0}};
        end else if (tp_i && (cnt_r != PER_W'(PER_MAX))) begin
            cnt_r <= cnt_r + PER_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Clamp the measured period into the representable tempo range.
    always_comb begin
        if (cnt_r < PER_W'(PER_MIN)) begin
            p_s = PER_W'(PER_MIN);
        end else if (cnt_r > PER_W'(PER_MAX)) begin
            p_s = PER_W'(PER_MAX);
        end else begin
            p_s = cnt_r;
        end
    end

    // Capture the period of every tap after the first; the ring update follows one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_r   <= {PER_W{1'b0}};
            upd_r <= 1'b0;
        end else begin
            upd_r <= tap_s && (state_r != ST_IDLE);
            p_r   <= tap_s ? p_s : p_r;
        end
    end

    // Running sum and fill level as they will be after a pending ring write.
    always_comb begin
        if (fill_r == FILL_W'(AVG_DEPTH)) begin
            oldest_s = ring_r[wr_ptr_r];
        end else begin
            oldest_s = {PER_W{1'b0}};
        end
        if (upd_r) begin
            sum_nx_s  = sum_r + SUM_W'(p_r) - SUM_W'(oldest_s);
            fill_nx_s = (fill_r == FILL_W'(AVG_DEPTH)) ? fill_r : fill_r + FILL_W'(1);
        end else begin
            sum_nx_s  = sum_r;
            fill_nx_s = fill_r;
        end
    end

    // Ring buffer, write pointer, sum and fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) begin
                ring_r[i] <= {PER_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else if (clear_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else if (upd_r) begin
            ring_r[wr_ptr_r] <= p_r;
            wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            sum_r            <= sum_nx_s;
            fill_r           <= fill_nx_s;
        end else begin
            wr_ptr_r <= wr_ptr_r;
            sum_r    <= sum_r;
            fill_r   <= fill_r;
        end
    end

    // Full-scale gap detection, only when the timeout build option is enabled.
    always_comb begin
`ifdef TAPTEMPO_TIMEOUT_EN
        timeout_s = (cnt_r == PER_W'(PER_MAX));
`else
        timeout_s = 1'b0;
`endif
    end

    // FSM state and pending-tap register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pend_r  <= pend_nx_s;
        end
    end

    // FSM next state: LOAD starts the divide with the post-update sum, DONE is the strobe cycle.
    always_comb begin
        state_nx_s = state_r;
        pend_nx_s  = pend_r;
        start_s    = 1'b0;
        clear_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tap_s) begin
                    state_nx_s = ST_COUNT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (tap_s) begin
                    state_nx_s = ST_LOAD;
                end else if (timeout_s) begin
                    state_nx_s = ST_IDLE;
                    clear_s    = 1'b1;
                end else begin
                    state_nx_s = ST_COUNT;
                end
            end
            ST_LOAD: begin
                start_s    = 1'b1;
                state_nx_s = ST_DIV;
                if (tap_s) begin
                    pend_nx_s = 1'b1;
                end else begin
                    pend_nx_s = pend_r;
                end
            end
            ST_DIV: begin
                if (tap_s) begin
                    pend_nx_s = 1'b1;
                end else begin
                    pend_nx_s = pend_r;
                end
                if (done_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DONE: begin
                pend_nx_s = 1'b0;
                if (pend_r || tap_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_COUNT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pend_nx_s  = 1'b0;
            end
        endcase
    end

    seqdiv #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W),
        .Q_W   (BPM_W)
    ) u_div (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_s),
        .num_i   (num_s),
        .den_i   (sum_nx_s),
        .q_o     (q_s),
        .done_o  (done_s)
    );

    // Registered outputs: result, strobe and busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bpm_o       <= {BPM_W{1'b0}};
            bpm_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            bpm_valid_o <= (state_r == ST_DIV) && done_s;
            bpm_o       <= ((state_r == ST_DIV) && done_s) ? q_s : bpm_o;
            busy_o      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_DIV);
        end
    end

endmodule

// File: tb/tb_taptempo_avg.sv
// Directed bench for taptempo_avg, scaled to TP_CYCLE = 1 ms: TPM = 60000, PER_MIN = 240, PER_MAX = 2000.
module tb_taptempo_avg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tp  = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] bpm;
    logic       valid;
    logic [2:0] fill;
    logic       busy;

    int n_chk     = 0;
    int n_pass    = 0;
    int since_tap = 0;

    always #5 clk = ~clk;

    taptempo_avg #(
        .TP_CYCLE  (32'd1_000_000),
        .BPM_MAX   (32'd250),
        .BPM_MIN   (32'd30),
        .AVG_DEPTH (32'd4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tp_i        (tp),
        .btn_i       (btn),
        .bpm_o       (bpm),
        .bpm_valid_o (valid),
        .fill_o      (fill),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        since_tap += n;
    endtask

    task automatic tap();
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        since_tap = 0;
    endtask

    task automatic tap_at(input int p);
        step(p - since_tap);
        tap();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Called one cycle after the tap; the strobe must land exactly 11 cycles after the tap cycle.
    task automatic expect_strobe(input string tag, input int exp_bpm, input int exp_fill);
        check({tag, ".busy_hi"}, busy, 1);
        step(9);
        check({tag, ".early"}, valid, 0);
        step(1);
        check({tag, ".valid"}, valid, 1);
        check({tag, ".bpm"}, bpm, exp_bpm);
        check({tag, ".fill"}, fill, exp_fill);
        check({tag, ".busy_lo"}, busy, 0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int pulses = 0;
        repeat (n) begin
            step(1);
            if (valid) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        do_reset();
        check("rst.bpm", bpm, 0);
        check("rst.valid", valid, 0);
        check("rst.fill", fill, 0);
        check("rst.busy", busy, 0);

        // Steady 500-tick taps: 120 BPM, fill climbing.
        tap();
        expect_quiet("t1.first_tap", 15);
        tap_at(500); expect_strobe("t1.s2", 120, 1);
        tap_at(500); expect_strobe("t1.s3", 120, 2);
        tap_at(500); expect_strobe("t1.s4", 120, 3);

        // 480 then 600: 60000/480 = 125, 120000/1080 = 111.
        do_reset();
        tap();
        tap_at(480); expect_strobe("t2.s1", 125, 1);
        tap_at(600); expect_strobe("t2.s2", 111, 2);

        // Too-fast tap is clamped to 240 ticks.
        do_reset();
        tap();
        tap_at(200); expect_strobe("t3.clamp", 250, 1);

        // Ring wrap: six periods of 240 then one of 480 -> sum 1200, 240000/1200 = 200.
        do_reset();
        tap();
        for (int i = 0; i < 6; i++) begin
            tap_at(240);
            expect_strobe($sformatf("t4.w%0d", i), 250, (i < 3) ? i + 1 : 4);
        end
        tap_at(480); expect_strobe("t4.mix", 200, 4);

        // Tap two cycles into a divide: first result 120, then 120000/740 = 162.
        do_reset();
        tap();
        tap_at(500);
        step(2);
        tap();
        step(6);
        check("t5.early", valid, 0);
        step(1);
        check("t5.valid1", valid, 1);
        check("t5.bpm1", bpm, 120);
        step(1);
        check("t5.restart_busy", busy, 1);
        step(9);
        check("t5.early2", valid, 0);
        step(1);
        check("t5.valid2", valid, 1);
        check("t5.bpm2", bpm, 162);
        check("t5.fill2", fill, 2);

`ifdef TAPTEMPO_TIMEOUT_EN
        // Gap beyond PER_MAX abandons the measurement; bpm holds, next tap restarts.
        do_reset();
        tap();
        tap_at(500); expect_strobe("t6.pre", 120, 1);
        step(2100);
        check("t6.fill_cleared", fill, 0);
        check("t6.bpm_held", bpm, 120);
        tap();
        expect_quiet("t6.no_strobe", 20);
        tap_at(500); expect_strobe("t6.restart", 120, 1);
`else
        // Gap beyond PER_MAX saturates at 2000 ticks -> 30 BPM.
        do_reset();
        tap();
        tap_at(2500); expect_strobe("t6.slow", 30, 1);
`endif

        // Reset mid-divide: everything zero and no strobe follows.
        do_reset();
        tap();
        tap_at(500); expect_strobe("t7.pre", 120, 1);
        tap_at(500);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t7.bpm", bpm, 0);
        check("t7.valid", valid, 0);
        check("t7.fill", fill, 0);
        check("t7.busy", busy, 0);
        expect_quiet("t7.no_strobe", 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
